// File: rtl/pps_pkg.sv
// Shared types and width helpers for the multi-channel PPS phase meter.
// Holds the FSM state enum, record flag layout and port width functions.
package pps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  typedef struct packed {
    logic missing;
    logic ambig;
    logic last;
  } rec_flags_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ph_w(input int win);
    return $clog2(win + 2) + 1;
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// Ports: i_clk, i_res_n (sync, active-low), i_async in, o_rise pulse.
module pps_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pps_phase_multi.sv
// Measures each channel PPS phase against a reference PPS in clk cycles.
// Ports: async i_ref_pps/i_pps in; o_valid/i_ready record stream out.
module pps_phase_multi
  import pps_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int WIN_CLKS    = 25000,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = ch_w(N_CH),
  localparam int PH_W        = ph_w(WIN_CLKS)
) (
  input  logic                   i_clk,
  input  logic                   i_res_n,
  input  logic                   i_ref_pps,
  input  logic [N_CH-1:0]        i_pps,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CH_W-1:0]        o_ch,
  output logic signed [PH_W-1:0] o_phase,
  output logic                   o_missing,
  output logic                   o_ambig,
  output logic                   o_last,
  output logic                   o_overrun,
  output logic                   o_busy
);

  localparam int CW = PH_W - 1;
  localparam logic [CW-1:0]   SAT      = CW'(WIN_CLKS + 1);
  localparam logic [CW-1:0]   WIN      = CW'(WIN_CLKS);
  localparam logic [CW-1:0]   LAST_CYC = CW'(WIN_CLKS - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  logic            ref_rise;
  logic [N_CH-1:0] ch_rise;

  pps_edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_async (i_ref_pps),
    .o_rise  (ref_rise)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pps_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_res_n (i_res_n),
      .i_async (i_pps[g]),
      .o_rise  (ch_rise[g])
    );
  end

  state_e state_q, state_d;

  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [CW-1:0]   pre_q  [N_CH];
  logic [CW-1:0]   pre_d  [N_CH];
  logic [CW-1:0]   post_q [N_CH];
  logic [CW-1:0]   post_d [N_CH];
  logic [N_CH-1:0] pre_v_q, pre_v_d;
  logic [N_CH-1:0] post_v_q, post_v_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [CH_W-1:0] idx_q, idx_d;

  logic                   valid_q, valid_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic signed [PH_W-1:0] phase_q, phase_d;
  rec_flags_t             flags_q, flags_d;
  logic                   ovr_q, ovr_d;

  logic start;
  logic xfer;
  logic load;

  logic signed [PH_W-1:0] rec_phase;
  rec_flags_t             rec_flags;
  logic signed [PH_W-1:0] pos_ph;
  logic signed [PH_W-1:0] neg_ph;

  assign start = (state_q == ST_IDLE) && ref_rise;
  assign xfer  = valid_q && i_ready;

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (ref_rise) state_d = ST_COLLECT;
      ST_COLLECT: if (cyc_q == LAST_CYC) state_d = ST_EMIT;
      ST_EMIT:    if (xfer && flags_q.last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Since-last counters: 1 the cycle after an edge, saturate at WIN+1
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_rise[i]) cnt_d[i] = CW'(1);
      else if (cnt_q[i] == SAT) cnt_d[i] = SAT;
      else cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  // Epoch capture: cycle 0 is still IDLE, so its edges land as post=0
  always_comb begin
    cyc_d    = cyc_q;
    pre_v_d  = pre_v_q;
    post_v_d = post_v_q;
    for (int i = 0; i < N_CH; i++) begin
      pre_d[i]  = pre_q[i];
      post_d[i] = post_q[i];
    end
    if (start) begin
      cyc_d = CW'(1);
      for (int i = 0; i < N_CH; i++) begin
        pre_d[i]    = cnt_q[i];
        pre_v_d[i]  = (cnt_q[i] != '0) && (cnt_q[i] <= WIN);
        post_d[i]   = '0;
        post_v_d[i] = ch_rise[i];
      end
    end else if (state_q == ST_COLLECT) begin
      cyc_d = cyc_q + CW'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (ch_rise[i] && !post_v_q[i]) begin
          post_v_d[i] = 1'b1;
          post_d[i]   = cyc_q;
        end
      end
    end
  end

  // Record for the channel idx_q points at
  always_comb begin
    pos_ph    = $signed({1'b0, post_q[idx_q]});
    neg_ph    = -$signed({1'b0, pre_q[idx_q]});
    rec_phase = '0;
    rec_flags = '0;
    rec_flags.last = (idx_q == LAST_CH);
    unique case ({post_v_q[idx_q], pre_v_q[idx_q]})
      2'b11: begin
        rec_flags.ambig = 1'b1;
        rec_phase = (post_q[idx_q] <= pre_q[idx_q]) ? pos_ph : neg_ph;
      end
      2'b10:   rec_phase = pos_ph;
      2'b01:   rec_phase = neg_ph;
      default: rec_flags.missing = 1'b1;
    endcase
  end

  // Output register / record sequencing
  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    phase_d = phase_q;
    flags_d = flags_q;
    idx_d   = idx_q;
    load    = 1'b0;
    ovr_d   = ref_rise && (state_q != ST_IDLE);
    if (start) idx_d = '0;
    if (state_q == ST_EMIT) begin
      if (!valid_q) begin
        load = 1'b1;
      end else if (xfer) begin
        if (flags_q.last) begin
          valid_d = 1'b0;
          ch_d    = '0;
          phase_d = '0;
          flags_d = '0;
        end else begin
          load = 1'b1;
        end
      end
    end
    if (load) begin
      valid_d = 1'b1;
      ch_d    = idx_q;
      phase_d = rec_phase;
      flags_d = rec_flags;
      idx_d   = idx_q + CH_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= SAT;
        pre_q[i]  <= '0;
        post_q[i] <= '0;
      end
      pre_v_q  <= '0;
      post_v_q <= '0;
      cyc_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      phase_q  <= '0;
      flags_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pre_q[i]  <= pre_d[i];
        post_q[i] <= post_d[i];
      end
      pre_v_q  <= pre_v_d;
      post_v_q <= post_v_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      phase_q  <= phase_d;
      flags_q  <= flags_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_ch      = ch_q;
  assign o_phase   = phase_q;
  assign o_missing = flags_q.missing;
  assign o_ambig   = flags_q.ambig;
  assign o_last    = flags_q.last;
  assign o_overrun = ovr_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
